ev_pwm_drive_stage: RTL and testbench
=====================================

EV_PWM_DRIVE_STAGE -- requirements
Module: ev_pwm_drive_stage

Interface
REQ-001 Parameter RAMP_DIV, default 16: clock cycles per one-LSB slew of duty_now (legal 1..65535).
REQ-002 Parameter PWM_BITS, default 8: PWM counter and duty width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  power-on from power control (1 = drive permitted).
REQ-006 speed_cmd  input  8  target duty from the motor-speed calculation stage.
REQ-007 speed_valid  input  1  one-cycle strobe; speed_cmd is captured only when high.
REQ-008 brake_active  input  1  brake pedal asserted.
REQ-009 fault_in  input  1  overcurrent/overtemp flag, level.
REQ-010 fault_clear  input  1  one-cycle request to leave FAULT.
REQ-011 pwm_out  output  1  motor gate drive.
REQ-012 duty_now  output  8  currently slewed duty value.
REQ-013 state  output  3  FSM state code.
REQ-014 ramp_busy  output  1  high while duty_now != target.
REQ-015 fault_latched  output  1  high in FAULT.

Function
REQ-016 Target register SHALL load speed_cmd on any cycle with speed_valid=1, otherwise hold; in BRAKE, OFF and FAULT the effective target SHALL be 0.
REQ-017 Prescaler SHALL count 0..RAMP_DIV-1 and wrap; on wrap, duty_now SHALL step +1 or -1 toward effective target, never overshoot.
REQ-018 In BRAKE, duty_now SHALL drop straight to 0 on the next clock (no slew).
REQ-019 PWM counter SHALL be free-running 0..255, wrapping 255->0.
REQ-020 Applied duty SHALL be copied from duty_now only when PWM counter = 255, so a period never sees a mid-period change.
REQ-021 pwm_out SHALL be registered, high when counter < applied duty; duty 0 => constantly low, duty 255 => high 255 of 256 cycles.
REQ-022 States: OFF=0, RAMP=1, RUN=2, BRAKE=3, FAULT=4; codes 5-7 unreachable, SHALL decode to OFF.
REQ-023 Priority per cycle: fault_in > !enable > brake_active > ramp logic.
REQ-024 Any state, fault_in=1 -> FAULT next clock; duty_now, applied duty and pwm_out SHALL be 0 in that same clock.
REQ-025 FAULT -> OFF only when fault_clear=1 and fault_in=0 in the same cycle; fault_clear while fault_in=1 is ignored.
REQ-026 Non-FAULT, enable=0 -> OFF; duty_now forced 0 immediately.
REQ-027 OFF -> RAMP when enable=1 and target != 0.
REQ-028 RAMP -> RUN when duty_now = target; RUN -> RAMP when a new target differs from duty_now.
REQ-029 RAMP/RUN -> BRAKE when brake_active=1; BRAKE -> RAMP when brake_active=0 and target != 0, else -> OFF.
REQ-030 ramp_busy SHALL equal (state=RAMP); fault_latched SHALL equal (state=FAULT).
REQ-031 speed_valid coincident with a prescaler wrap: slew SHALL use the newly captured target.

Reset
REQ-032 rst=1 SHALL asynchronously force state=OFF, target=0, duty_now=0, applied duty=0, prescaler=0, PWM counter=0, pwm_out=0, ramp_busy=0, fault_latched=0.
REQ-033 Reset mid-ramp or in FAULT SHALL discard all state; first post-reset cycle behaves as cold start.

Structure
REQ-034 State encodings and default RAMP_DIV/PWM_BITS SHALL live in shared package ev_ctrl_pkg.
REQ-035 PWM counter, applied-duty latch and compare SHALL be one sub-module, pwm_gen; FSM and slew stay in the top.

Verification
REQ-036 enable=1, speed_cmd=100 strobed, RAMP_DIV=16 -> RAMP, duty_now reaches 100 after 1600±16 cycles, then RUN, ramp_busy=0.
REQ-037 RUN at 100, brake_active=1 -> BRAKE and duty_now=0 next clock; release -> RAMP back toward 100.
REQ-038 RUN at 200, fault_in pulse -> FAULT, pwm_out=0 within 1 clock; fault_clear with fault_in=1 ignored; with fault_in=0 -> OFF.
REQ-039 speed_cmd changes 50->30 mid-period -> pwm_out high-time changes only at the counter wrap; high count per period equals applied duty exactly.
REQ-040 rst asserted mid-ramp (duty_now=37) -> all outputs 0 asynchronously, state=OFF.
REQ-041 duty 0 and 255 -> pwm_out 0/256 and 255/256 high cycles per period.

Source files
------------

// File: rtl/ev_ctrl_pkg.sv
// rtl/ev_ctrl_pkg.sv - shared state codes and defaults for the EV drive stage
package ev_ctrl_pkg;
   localparam int RAMP_DIV_DEFAULT = 16;
   localparam int PWM_BITS_DEFAULT = 8;
   localparam int PRESC_W          = 16;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_RAMP  = 3'd1,
      ST_RUN   = 3'd2,
      ST_BRAKE = 3'd3,
      ST_FAULT = 3'd4
   } drive_state_e;
endpackage

// File: rtl/ev_pwm_drive_stage_if.sv
// rtl/ev_pwm_drive_stage_if.sv - control/status bundle between power control and the drive stage
interface ev_pwm_drive_stage_if
   import ev_ctrl_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEFAULT
);
   logic                enable;
   logic [PWM_BITS-1:0] speed_cmd;
   logic                speed_valid;
   logic                brake_active;
   logic                fault_in;
   logic                fault_clear;
   logic                pwm_out;
   logic [PWM_BITS-1:0] duty_now;
   logic [2:0]          state;
   logic                ramp_busy;
   logic                fault_latched;

   modport master (
      output enable, speed_cmd, speed_valid, brake_active, fault_in, fault_clear,
      input  pwm_out, duty_now, state, ramp_busy, fault_latched
   );

   modport slave (
      input  enable, speed_cmd, speed_valid, brake_active, fault_in, fault_clear,
      output pwm_out, duty_now, state, ramp_busy, fault_latched
   );
endinterface

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running PWM counter with period-aligned duty latch and registered compare
module pwm_gen
   import ev_ctrl_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                kill_i,
   input  logic [PWM_BITS-1:0] duty_i,
   output logic                pwm_o
);
   logic [PWM_BITS-1:0] cnt_q;
   logic [PWM_BITS-1:0] applied_q;
   logic                pwm_q;

   // Duty is only picked up on the last count so each period is uniform;
   // kill bypasses that and drops the gate in the same clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         applied_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         cnt_q <= cnt_q + PWM_BITS'(1);
         if (kill_i) begin
            applied_q <= '0;
            pwm_q     <= 1'b0;
         end else begin
            pwm_q <= (cnt_q < applied_q);
            if (&cnt_q) begin
               applied_q <= duty_i;
            end
         end
      end
   end

   assign pwm_o = pwm_q;
endmodule

// File: rtl/ev_pwm_drive_stage.sv
// rtl/ev_pwm_drive_stage.sv - EV motor drive stage: mode FSM, slewed duty and gate PWM
module ev_pwm_drive_stage
   import ev_ctrl_pkg::*;
#(
   parameter int RAMP_DIV = RAMP_DIV_DEFAULT,
   parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
   input logic                  clk,
   input logic                  rst,
   ev_pwm_drive_stage_if.slave  bus
);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

   drive_state_e        state_q, state_d;
   logic [PWM_BITS-1:0] target_q, target_d;
   logic [PWM_BITS-1:0] duty_q, duty_d, duty_step;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic                ramp_busy_q, fault_latched_q;
   logic                wrap, pwm_kill, pwm;

   // A strobe on a wrap cycle slews toward the freshly captured value.
   assign target_d = bus.speed_valid ? bus.speed_cmd : target_q;
   assign wrap     = (presc_q == PRESC_LAST);
   assign presc_d  = wrap ? '0 : presc_q + PRESC_W'(1);

   always_comb begin
      duty_step = duty_q;
      if (wrap && (duty_q < target_d)) begin
         duty_step = duty_q + PWM_BITS'(1);
      end else if (wrap && (duty_q > target_d)) begin
         duty_step = duty_q - PWM_BITS'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      if (bus.fault_in) begin
         state_d = ST_FAULT;
         duty_d  = '0;
      end else if (state_q == ST_FAULT) begin
         duty_d = '0;
         if (bus.fault_clear) begin
            state_d = ST_OFF;
         end
      end else if (!bus.enable) begin
         state_d = ST_OFF;
         duty_d  = '0;
      end else if (bus.brake_active) begin
         duty_d  = '0;
         state_d = (state_q == ST_RAMP || state_q == ST_RUN || state_q == ST_BRAKE) ? ST_BRAKE : ST_OFF;
      end else begin
         case (state_q)
            ST_RAMP, ST_RUN: begin
               duty_d  = duty_step;
               state_d = (duty_q == target_d) ? ST_RUN : ST_RAMP;
            end
            // OFF, BRAKE and the unused codes all start a ramp from zero
            default: begin
               duty_d  = '0;
               state_d = (target_d != '0) ? ST_RAMP : ST_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_OFF;
         target_q        <= '0;
         duty_q          <= '0;
         presc_q         <= '0;
         ramp_busy_q     <= 1'b0;
         fault_latched_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         target_q        <= target_d;
         duty_q          <= duty_d;
         presc_q         <= presc_d;
         ramp_busy_q     <= (state_d == ST_RAMP);
         fault_latched_q <= (state_d == ST_FAULT);
      end
   end

   assign pwm_kill = bus.fault_in | (state_q == ST_FAULT);

   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_gen (
      .clk    (clk),
      .rst    (rst),
      .kill_i (pwm_kill),
      .duty_i (duty_q),
      .pwm_o  (pwm)
   );

   assign bus.pwm_out       = pwm;
   assign bus.duty_now      = duty_q;
   assign bus.state         = state_q;
   assign bus.ramp_busy     = ramp_busy_q;
   assign bus.fault_latched = fault_latched_q;
endmodule

// File: tb/tb_ev_pwm_drive_stage.sv
// tb/tb_ev_pwm_drive_stage.sv - scoreboard bench for ev_pwm_drive_stage
module tb_ev_pwm_drive_stage;
   localparam int RAMP_DIV = 16;
   localparam int S_OFF = 0, S_RAMP = 1, S_RUN = 2, S_BRAKE = 3, S_FAULT = 4;

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] duty;
      logic       pwm;
      logic       busy;
      logic       flt;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, sv = 1'b0, br = 1'b0, fi = 1'b0, fc = 1'b0;
   logic [7:0] cmd = 8'd0;
   int         tests = 0;
   int         fails = 0;
   obs_t       exp_q[$];
   obs_t       mon_e, mon_a;
   int         m_state, m_target, m_duty, m_applied, m_k;
   logic       m_pwm;

   ev_pwm_drive_stage_if #(.PWM_BITS(8)) bus ();

   ev_pwm_drive_stage #(.RAMP_DIV(RAMP_DIV), .PWM_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: k counts clocks since reset, so prescaler = k mod RAMP_DIV and PWM counter = k mod 256.
   task automatic model_step();
      int tgt, pcnt;
      bit wrap;
      tgt  = sv ? int'(cmd) : m_target;
      wrap = ((m_k % RAMP_DIV) == RAMP_DIV - 1);
      pcnt = m_k % 256;
      if (fi) begin
         m_pwm     = 1'b0;
         m_applied = 0;
      end else begin
         m_pwm = (pcnt < m_applied);
         if (pcnt == 255) m_applied = m_duty;
      end
      if (fi) begin
         m_state = S_FAULT;
         m_duty  = 0;
      end else if (m_state == S_FAULT) begin
         if (fc) m_state = S_OFF;
      end else if (!en) begin
         m_state = S_OFF;
         m_duty  = 0;
      end else if (br) begin
         if (m_state != S_OFF) m_state = S_BRAKE;
         m_duty = 0;
      end else if (m_state == S_OFF || m_state == S_BRAKE) begin
         m_state = (tgt != 0) ? S_RAMP : S_OFF;
      end else begin
         m_state = (m_duty == tgt) ? S_RUN : S_RAMP;
         if (wrap && tgt > m_duty) m_duty = m_duty + 1;
         else if (wrap && tgt < m_duty) m_duty = m_duty - 1;
      end
      m_target = tgt;
      m_k      = m_k + 1;
   endtask

   task automatic apply();
      bus.enable       = en;
      bus.speed_cmd    = cmd;
      bus.speed_valid  = sv;
      bus.brake_active = br;
      bus.fault_in     = fi;
      bus.fault_clear  = fc;
      model_step();
      exp_q.push_back({3'(m_state), 8'(m_duty), m_pwm, m_state == S_RAMP, m_state == S_FAULT});
   endtask

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(negedge clk);
         apply();
      end
   endtask

   task automatic strobe(int v);
      cmd = 8'(v);
      sv  = 1'b1;
      cyc();
      sv  = 1'b0;
   endtask

   task automatic chk(string name, int act, int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic wait_duty(string name, int v, int budget, output int n);
      n = 0;
      while (int'(bus.duty_now) != v && n < budget) begin
         cyc();
         n++;
      end
      tests++;
      if (int'(bus.duty_now) != v) begin
         fails++;
         $display("FAIL %s: duty_now %0d after %0d cycles, want %0d", name, bus.duty_now, n, v);
      end
   endtask

   task automatic count_high(output int h);
      h = 0;
      repeat (256) begin
         cyc();
         h += int'(bus.pwm_out);
      end
   endtask

   task automatic do_reset(bit check);
      @(posedge clk);
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      if (check) begin
         chk("rst_state", int'(bus.state), S_OFF);
         chk("rst_duty", int'(bus.duty_now), 0);
         chk("rst_pwm", int'(bus.pwm_out), 0);
         chk("rst_busy", int'(bus.ramp_busy), 0);
         chk("rst_fault_latched", int'(bus.fault_latched), 0);
      end
      en = 1'b0; sv = 1'b0; br = 1'b0; fi = 1'b0; fc = 1'b0; cmd = 8'd0;
      repeat (3) @(negedge clk);
      rst       = 1'b0;
      m_state   = S_OFF;
      m_target  = 0;
      m_duty    = 0;
      m_applied = 0;
      m_k       = 0;
      m_pwm     = 1'b0;
      apply();
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {bus.state, bus.duty_now, bus.pwm_out, bus.ramp_busy, bus.fault_latched};
            tests++;
            if (mon_a !== mon_e) begin
               fails++;
               $display("FAIL scoreboard @%0t: got st=%0d duty=%0d pwm=%0b busy=%0b flt=%0b want st=%0d duty=%0d pwm=%0b busy=%0b flt=%0b",
                        $time, mon_a.st, mon_a.duty, mon_a.pwm, mon_a.busy, mon_a.flt,
                        mon_e.st, mon_e.duty, mon_e.pwm, mon_e.busy, mon_e.flt);
            end
         end
      end
   end

   initial begin
      #20000000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int n, h, len, sv_div;
      bus.enable = 1'b0; bus.speed_cmd = 8'd0; bus.speed_valid = 1'b0;
      bus.brake_active = 1'b0; bus.fault_in = 1'b0; bus.fault_clear = 1'b0;
      do_reset(1'b1);

      en = 1'b1;
      cyc(3);
      chk("off_without_target", int'(bus.state), S_OFF);
      strobe(100);
      wait_duty("ramp_to_100", 100, 2000, n);
      tests++;
      if (n < 1584 || n > 1616) begin
         fails++;
         $display("FAIL ramp_time: got %0d cycles want 1584..1616", n);
      end
      cyc(2);
      chk("run_state", int'(bus.state), S_RUN);
      chk("run_ramp_busy", int'(bus.ramp_busy), 0);

      br = 1'b1;
      cyc(2);
      chk("brake_state", int'(bus.state), S_BRAKE);
      chk("brake_duty", int'(bus.duty_now), 0);
      br = 1'b0;
      cyc(2);
      chk("brake_release_state", int'(bus.state), S_RAMP);
      wait_duty("reramp_to_100", 100, 2000, n);

      strobe(200);
      wait_duty("ramp_to_200", 200, 2000, n);
      cyc(300);
      count_high(h);
      chk("high_count_200", h, 200);
      fi = 1'b1;
      cyc(2);
      chk("fault_state", int'(bus.state), S_FAULT);
      chk("fault_duty", int'(bus.duty_now), 0);
      chk("fault_pwm", int'(bus.pwm_out), 0);
      chk("fault_latched", int'(bus.fault_latched), 1);
      fc = 1'b1;
      cyc();
      fc = 1'b0;
      cyc(2);
      chk("clear_while_fault_ignored", int'(bus.state), S_FAULT);
      fi = 1'b0;
      cyc(2);
      chk("fault_holds", int'(bus.state), S_FAULT);
      fc = 1'b1;
      cyc();
      fc = 1'b0;
      cyc();
      chk("fault_cleared", int'(bus.state), S_OFF);

      strobe(50);
      wait_duty("ramp_to_50", 50, 1200, n);
      cyc(300);
      count_high(h);
      chk("high_count_50", h, 50);
      strobe(30);
      wait_duty("ramp_to_30", 30, 600, n);
      cyc(300);
      count_high(h);
      chk("high_count_30", h, 30);
      strobe(0);
      wait_duty("ramp_to_0", 0, 800, n);
      cyc(300);
      count_high(h);
      chk("high_count_0", h, 0);
      strobe(255);
      wait_duty("ramp_to_255", 255, 4300, n);
      cyc(300);
      count_high(h);
      chk("high_count_255", h, 255);

      do_reset(1'b0);
      en = 1'b1;
      strobe(100);
      wait_duty("ramp_to_37", 37, 1000, n);
      do_reset(1'b1);
      cyc(2);
      chk("cold_state", int'(bus.state), S_OFF);
      chk("cold_duty", int'(bus.duty_now), 0);
      en = 1'b1;
      cyc(3);
      chk("cold_target_cleared", int'(bus.state), S_OFF);

      for (int seg = 0; seg < 30; seg++) begin
         if ($urandom_range(0, 7) == 0) do_reset(1'b1);
         en     = ($urandom_range(0, 9) != 0);
         br     = ($urandom_range(0, 5) == 0);
         sv_div = ($urandom_range(0, 1) == 0) ? 8 : 1500;
         len    = int'($urandom_range(40, 700));
         for (int i = 0; i < len; i++) begin
            sv  = ($urandom_range(0, sv_div - 1) == 0);
            cmd = 8'($urandom_range(0, 255));
            fi  = ($urandom_range(0, 599) == 0);
            fc  = ($urandom_range(0, 31) == 0);
            cyc();
         end
      end
      sv = 1'b0; fi = 1'b0; fc = 1'b0;
      cyc(2);
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
